// File: rtl/fifo_rd_stream_if.sv
// Output stream of the FIFO read side: valid/ready handshake with data and burst-last flag.
interface fifo_rd_stream_if #(
  parameter int D_SIZE = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [D_SIZE-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Pops an async-FIFO read port into a 2-entry skid buffer and streams it out with burst framing.
// Pop-to-m_valid latency 1 cycle; m_ready low fills the buffer, then pops stop until a transfer frees a slot.
module fifo_rd_stream #(
  parameter int D_SIZE    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              r_clk,
  input  logic              r_rstn,
  input  logic              en,
  input  logic              empty,
  input  logic [D_SIZE-1:0] rd_data,
  output logic              r_inc,
  output logic [CNT_W-1:0]  pop_cnt,
  output logic              busy,
  fifo_rd_stream_if.master  m
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = BW + 2;

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              buf_cnt_q, buf_cnt_d, cnt_keep;
  logic [1:0][D_SIZE-1:0]  dat_q, dat_d;
  logic [1:0]              last_q, last_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [CNT_W-1:0]        pop_cnt_q, pop_cnt_d;
  logic                    pop_q, rst_done_q, busy_q;
  logic                    m_valid, xfer, may_pop, new_last;
  logic [SW-1:0]           pos;

  assign m_valid = (buf_cnt_q != 2'd0);
  assign xfer    = m_valid & m.m_ready;

  always_comb begin
    may_pop = (state_q == ACTIVE) | ((state_q == IDLE) & en);
    // rst_done_q holds off any pop until the first edge after reset release
    r_inc   = rst_done_q & may_pop & en & ~empty & ~pop_q & ((buf_cnt_q != 2'd2) | xfer);

    // Beat index of the incoming word = head beat + words already queued ahead of it
    pos      = SW'(beat_q) + SW'(buf_cnt_q);
    new_last = (pos == SW'(BURST_LEN - 1)) | (pos == SW'(2 * BURST_LEN - 1)) |
               (pos == SW'(3 * BURST_LEN - 1));

    cnt_keep = buf_cnt_q - {1'b0, xfer};
    dat_d    = dat_q;
    last_d   = last_q;
    if (xfer) begin
      dat_d[0]  = dat_q[1];
      last_d[0] = last_q[1];
    end
    if (r_inc) begin
      dat_d[cnt_keep[0]]  = rd_data;
      last_d[cnt_keep[0]] = new_last;
    end
    buf_cnt_d = cnt_keep + {1'b0, r_inc};

    beat_d = beat_q;
    if (xfer) beat_d = (beat_q == BW'(BURST_LEN - 1)) ? '0 : beat_q + BW'(1);

    pop_cnt_d = pop_cnt_q + CNT_W'(r_inc);

    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = ACTIVE;
      ACTIVE:  if (!en) state_d = (buf_cnt_d != 2'd0) ? FLUSH : IDLE;
      FLUSH: begin
        if (en)                       state_d = ACTIVE;
        else if (buf_cnt_d == 2'd0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state_q    <= IDLE;
      buf_cnt_q  <= 2'd0;
      dat_q      <= '0;
      last_q     <= '0;
      beat_q     <= '0;
      pop_cnt_q  <= '0;
      pop_q      <= 1'b0;
      rst_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_cnt_q  <= buf_cnt_d;
      dat_q      <= dat_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      pop_cnt_q  <= pop_cnt_d;
      pop_q      <= r_inc;
      rst_done_q <= 1'b1;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign m.m_valid = m_valid;
  assign m.m_data  = dat_q[0];
  assign m.m_last  = last_q[0] & m_valid;
  assign pop_cnt   = pop_cnt_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: stimulus loads a modelled async FIFO and queues expected beats; a monitor checks transfers.
module tb_fifo_rd_stream;
  logic        clk;
  logic        rstn, en, ready, empty_q;
  logic [7:0]  rd_data;
  logic        r_inc, r_inc4, busy, busy4;
  logic [15:0] pop_cnt;
  logic [3:0]  pop_cnt4;

  fifo_rd_stream_if #(.D_SIZE(8)) s_if ();
  fifo_rd_stream_if #(.D_SIZE(8)) s4_if ();
  assign s_if.m_ready  = ready;
  assign s4_if.m_ready = ready;

  fifo_rd_stream #(.D_SIZE(8), .BURST_LEN(4), .CNT_W(16)) dut (
    .r_clk(clk), .r_rstn(rstn), .en(en), .empty(empty_q), .rd_data(rd_data),
    .r_inc(r_inc), .pop_cnt(pop_cnt), .busy(busy), .m(s_if.master));

  // Identical twin with a 4-bit pop counter, fed the same inputs, for the wrap check
  fifo_rd_stream #(.D_SIZE(8), .BURST_LEN(4), .CNT_W(4)) dut4 (
    .r_clk(clk), .r_rstn(rstn), .en(en), .empty(empty_q), .rd_data(rd_data),
    .r_inc(r_inc4), .pop_cnt(pop_cnt4), .busy(busy4), .m(s4_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int beat_m = 0;
  logic [8:0] exp_q [$];
  logic prev_inc;

  assign rd_data = mem[rd_ptr[7:0]];

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endfunction

  // Async-FIFO read side: empty lags a pop by one cycle
  always @(posedge clk) begin
    int avail;
    avail = wr_ptr - rd_ptr;
    if (!rstn) begin
      rd_ptr   <= wr_ptr;
      empty_q  <= 1'b1;
      prev_inc <= 1'b0;
    end else begin
      if (r_inc) begin
        chk("no_back_to_back_pop", int'(prev_inc), 0);
        chk("no_underflow", int'(avail > 0), 1);
        rd_ptr <= rd_ptr + 1;
      end
      empty_q  <= (avail == 0);
      prev_inc <= r_inc;
    end
  end

  logic       stall_prev;
  logic [7:0] hold_dat;
  logic       hold_last;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rstn !== 1'b1) begin
      stall_prev = 1'b0;
    end else begin
      if (s_if.m_valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(s_if.m_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", int'(s_if.m_data), int'(e[7:0]));
          chk("m_last", int'(s_if.m_last), int'(e[8]));
        end
      end
      if (stall_prev && s_if.m_valid) begin
        chk("hold_data", int'(s_if.m_data), int'(hold_dat));
        chk("hold_last", int'(s_if.m_last), int'(hold_last));
      end
      stall_prev = s_if.m_valid && !ready;
      hold_dat   = s_if.m_data;
      hold_last  = s_if.m_last;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] base, input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = base + 8'(i);
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
      exp_q.push_back({beat_m == 3, w});
      beat_m = (beat_m + 1) % 4;
    end
  endtask

  task automatic wait_exp(input int size, input int budget);
    int n = 0;
    while (exp_q.size() != size && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), size);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (int'(pop_cnt) != target && n < budget) begin
      tick();
      n++;
    end
    chk("pop_timeout", int'(pop_cnt), target);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rstn = 1'b0; en = 1'b0; ready = 1'b0;
    tick(3);
    chk("rst_m_valid", int'(s_if.m_valid), 0);
    chk("rst_m_data", int'(s_if.m_data), 0);
    chk("rst_m_last", int'(s_if.m_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_r_inc", int'(r_inc), 0);
    chk("rst_pop_cnt", int'(pop_cnt), 0);
    rstn = 1'b1;

    // Enabled with nothing to read
    en = 1'b1;
    tick(6);
    chk("empty_r_inc", int'(r_inc), 0);
    chk("empty_m_valid", int'(s_if.m_valid), 0);
    chk("empty_busy", int'(busy), 1);
    chk("empty_pop_cnt", int'(pop_cnt), 0);

    // Free-running stream of 8 words
    ready = 1'b1;
    load(8'h01, 8);
    wait_exp(0, 100);
    tick(2);
    chk("stream_pop_cnt", int'(pop_cnt), 8);

    // Downstream stalled: buffer fills with exactly 2 words
    ready = 1'b0;
    load(8'h09, 8);
    wait_pops(10, 50);
    tick(10);
    chk("stall_pop_cnt", int'(pop_cnt), 10);
    chk("stall_r_inc", int'(r_inc), 0);
    chk("stall_m_valid", int'(s_if.m_valid), 1);
    chk("stall_m_data", int'(s_if.m_data), 8'h09);
    ready = 1'b1;
    wait_exp(0, 100);
    chk("stall_drain_pop_cnt", int'(pop_cnt), 16);

    // Disable with 2 words buffered: flush them without popping more
    ready = 1'b0;
    load(8'h11, 4);
    wait_pops(18, 50);
    tick(2);
    en = 1'b0;
    tick(6);
    chk("flush_pop_cnt", int'(pop_cnt), 18);
    chk("flush_busy", int'(busy), 1);
    chk("flush_m_valid", int'(s_if.m_valid), 1);
    ready = 1'b1;
    wait_exp(2, 50);
    tick(3);
    chk("flush_idle_busy", int'(busy), 0);
    chk("flush_idle_m_valid", int'(s_if.m_valid), 0);
    chk("flush_idle_pop_cnt", int'(pop_cnt), 18);
    en = 1'b1;
    wait_exp(0, 100);
    chk("resume_pop_cnt", int'(pop_cnt), 20);

    // Reset mid-burst with the buffer full
    load(8'h21, 1);
    wait_exp(0, 50);
    ready = 1'b0;
    load(8'h22, 3);
    wait_pops(23, 50);
    tick(2);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_m_valid", int'(s_if.m_valid), 0);
    chk("midrst_pop_cnt", int'(pop_cnt), 0);
    chk("midrst_r_inc", int'(r_inc), 0);
    chk("midrst_pop_cnt4", int'(pop_cnt4), 0);
    exp_q.delete();
    beat_m = 0;
    tick(3);
    rstn = 1'b1;
    ready = 1'b1;
    load(8'h30, 17);
    wait_exp(0, 200);
    tick(2);
    chk("restart_pop_cnt", int'(pop_cnt), 17);
    chk("wrap_pop_cnt4", int'(pop_cnt4), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
